// File: rtl/la_pkg.sv
// Shared types and constants for the logic-analyser capture engine.
package la_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRETRIG   = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_DONE      = 3'd4
    } la_state_t;

    localparam logic TRIG_LEVEL = 1'b0;
    localparam logic TRIG_EDGE  = 1'b1;
    localparam logic COMB_OR    = 1'b0;
    localparam logic COMB_AND   = 1'b1;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/la_sdp_ram.sv
// Simple dual-port capture buffer: one write port, one registered read port.
module la_sdp_ram
    import la_pkg::*;
#(
    parameter  int DATA_W = 13,
    parameter  int DEPTH  = 1024,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Only the read latch is reset; it holds its value when re is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/la_capture_core.sv
// Logic-analyser capture engine: circular sample buffer with programmable
// pre-trigger depth and maskable level/edge trigger channels.
module la_capture_core
    import la_pkg::*;
#(
    parameter  int DATA_W = 13,
    parameter  int DEPTH  = 1024,
    parameter  int TRIG_W = 4,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              arm_i,
    input  logic              abort_i,
    input  logic [TRIG_W-1:0] trig_i,
    input  logic [TRIG_W-1:0] trig_mask_i,
    input  logic              trig_edge_i,
    input  logic              trig_and_i,
    input  logic [ADDR_W-1:0] pretrig_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic [2:0]        state_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] trig_addr_o
);

    la_state_t         state, state_nxt;
    logic [ADDR_W-1:0] wr_ptr, pre_len, pre_cnt, post_rem, trig_addr;
    logic [ADDR_W-1:0] pre_req, rd_phys;
    logic [TRIG_W-1:0] trig_prev, hit_ch;
    logic              hit, wr_en, rd_fire, done, rd_valid;

    assign hit_ch  = (trig_edge_i == TRIG_EDGE) ? (trig_i & ~trig_prev) : trig_i;
    // The mask guard keeps AND-combine from hitting vacuously with no channels.
    assign hit     = (|trig_mask_i) &&
                     ((trig_and_i == COMB_AND) ? (&(hit_ch | ~trig_mask_i))
                                               : (|(hit_ch & trig_mask_i)));
    assign pre_req = (pretrig_i > ADDR_W'(DEPTH - 1)) ? ADDR_W'(DEPTH - 1) : pretrig_i;
    assign wr_en   = (state == ST_PRETRIG) || (state == ST_WAIT_TRIG) || (state == ST_POST);
    assign rd_fire = rd_en_i && (state == ST_DONE);
    assign rd_phys = trig_addr - pre_len + rd_addr_i;

    always_comb begin
        state_nxt = state;
        if (abort_i) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE:
                    if (arm_i) state_nxt = (pre_req == '0) ? ST_WAIT_TRIG : ST_PRETRIG;
                ST_PRETRIG:
                    if (pre_cnt == ADDR_W'(1)) state_nxt = ST_WAIT_TRIG;
                ST_WAIT_TRIG:
                    if (hit) state_nxt = (pre_len == ADDR_W'(DEPTH - 1)) ? ST_DONE : ST_POST;
                ST_POST:
                    if (post_rem == ADDR_W'(1)) state_nxt = ST_DONE;
                default:
                    state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            pre_len   <= '0;
            pre_cnt   <= '0;
            post_rem  <= '0;
            trig_addr <= '0;
            trig_prev <= '0;
            done      <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            state     <= state_nxt;
            trig_prev <= trig_i;
            done      <= (state_nxt == ST_DONE);
            rd_valid  <= rd_fire;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            case (state)
                ST_IDLE, ST_DONE:
                    if (arm_i && !abort_i) begin
                        wr_ptr  <= '0;
                        pre_len <= pre_req;
                        pre_cnt <= pre_req;
                    end
                ST_PRETRIG:
                    pre_cnt <= pre_cnt - 1'b1;
                ST_WAIT_TRIG:
                    if (hit) begin
                        trig_addr <= wr_ptr;
                        post_rem  <= ADDR_W'(DEPTH - 1) - pre_len;
                    end
                ST_POST:
                    post_rem <= post_rem - 1'b1;
                default: ;
            endcase
        end
    end

    la_sdp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk_i),
        .rst   (rst_i),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (data_i),
        .re    (rd_fire),
        .raddr (rd_phys),
        .rdata (rd_data_o)
    );

    assign rd_valid_o  = rd_valid;
    assign state_o     = state;
    assign done_o      = done;
    assign trig_addr_o = trig_addr;

endmodule

// File: tb/tb_la_capture_core.sv
// Bench for la_capture_core: directed trigger table, random captures checked
// against a cycle-timeline trigger model, and abort/reset sequences.
module tb_la_capture_core;

    localparam int DATA_W = 13;
    localparam int DEPTH  = 16;
    localparam int TRIG_W = 4;
    localparam int ADDR_W = 4;

    logic              clk_i = 1'b0, rst_i = 1'b1, arm_i = 1'b0, abort_i = 1'b0;
    logic              trig_edge_i = 1'b0, trig_and_i = 1'b0, rd_en_i = 1'b0;
    logic [TRIG_W-1:0] trig_i = '0, trig_mask_i = '0;
    logic [ADDR_W-1:0] pretrig_i = '0, rd_addr_i = '0;
    logic [DATA_W-1:0] data_i = '0;
    logic [DATA_W-1:0] rd_data_o;
    logic              rd_valid_o, done_o;
    logic [2:0]        state_o;
    logic [ADDR_W-1:0] trig_addr_o;

    int vectors = 0, miscompares = 0, n = 0;

    la_capture_core #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TRIG_W(TRIG_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .arm_i(arm_i), .abort_i(abort_i),
        .trig_i(trig_i), .trig_mask_i(trig_mask_i), .trig_edge_i(trig_edge_i),
        .trig_and_i(trig_and_i), .pretrig_i(pretrig_i), .data_i(data_i),
        .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
        .rd_valid_o(rd_valid_o), .state_o(state_o), .done_o(done_o),
        .trig_addr_o(trig_addr_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Each channel is high in [on_a,off_a) and [on_b,off_b), in cycles relative to arm.
    typedef struct packed {
        logic [3:0]       pretrig;
        logic [3:0]       mask;
        logic             edge_m;
        logic             and_m;
        logic [3:0][15:0] on_a;
        logic [3:0][15:0] off_a;
        logic [3:0][15:0] on_b;
        logic [3:0][15:0] off_b;
        int               exp_t;
    } vec_t;

    vec_t tbl [10];

    function automatic vec_t mk(input int pt, input int mask, input logic e, input logic an,
                                input int t);
        vec_t v;
        v = '0;
        v.pretrig = 4'(pt);
        v.mask    = 4'(mask);
        v.edge_m  = e;
        v.and_m   = an;
        v.exp_t   = t;
        return v;
    endfunction

    function automatic vec_t chw(input vec_t v0, input int ch, input int on0, input int off0,
                                 input int on1, input int off1);
        vec_t v;
        v = v0;
        v.on_a[ch]  = 16'(on0);
        v.off_a[ch] = 16'(off0);
        v.on_b[ch]  = 16'(on1);
        v.off_b[ch] = 16'(off1);
        return v;
    endfunction

    function automatic logic lvl(input vec_t v, input int ch, input int rel);
        int on0, off0, on1, off1;
        on0  = int'($signed(v.on_a[ch]));
        off0 = int'($signed(v.off_a[ch]));
        on1  = int'($signed(v.on_b[ch]));
        off1 = int'($signed(v.off_b[ch]));
        return (rel >= on0 && rel < off0) || (rel >= on1 && rel < off1);
    endfunction

    function automatic logic [3:0] stim(input vec_t v, input int rel);
        logic [3:0] s;
        for (int ch = 0; ch < 4; ch++) s[ch] = lvl(v, ch, rel);
        return s;
    endfunction

    // First cycle after the pre-trigger fill at which the combined condition holds.
    function automatic int model_trig(input vec_t v);
        int pl;
        bit any, all, h;
        pl = int'(v.pretrig);
        for (int rel = pl + 1; rel < 300; rel++) begin
            any = 1'b0;
            all = 1'b1;
            for (int ch = 0; ch < 4; ch++) begin
                if (v.mask[ch]) begin
                    h = v.edge_m ? (lvl(v, ch, rel) && !lvl(v, ch, rel - 1)) : lvl(v, ch, rel);
                    any = any | h;
                    all = all & h;
                end
            end
            if (v.mask != 4'd0 && (v.and_m ? all : any)) return rel;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
        n++;
        data_i = DATA_W'(n);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic run_capture(input vec_t v, input int exp_t, input string nm);
        int a, pl, done_rel;
        a  = n + 3;
        pl = (int'(v.pretrig) > DEPTH - 1) ? DEPTH - 1 : int'(v.pretrig);
        pretrig_i   = v.pretrig;
        trig_mask_i = v.mask;
        trig_edge_i = v.edge_m;
        trig_and_i  = v.and_m;
        done_rel    = -1;
        for (int rel = -3; rel < 400 && done_rel < 0; rel++) begin
            arm_i  = (rel == 0);
            trig_i = stim(v, rel);
            step();
            if (rel > 0 && done_o) done_rel = rel;
        end
        arm_i = 1'b0;
        chk({nm, " done_time"}, 32'(done_rel), 32'(exp_t + DEPTH - 1 - pl));
        chk({nm, " state_done"}, 32'(state_o), 32'd4);
        chk({nm, " trig_addr"}, 32'(trig_addr_o), 32'((exp_t - 1) % DEPTH));
        for (int k = 0; k < DEPTH; k++) begin
            rd_en_i   = 1'b1;
            rd_addr_i = ADDR_W'(k);
            step();
            chk({nm, " rd_valid"}, 32'(rd_valid_o), 32'd1);
            chk({nm, " rd_data"}, 32'(rd_data_o), 32'((a + exp_t - pl + k) % (1 << DATA_W)));
        end
        rd_en_i = 1'b0;
        step();
        chk({nm, " rd_valid_pulse"}, 32'(rd_valid_o), 32'd0);
    endtask

    initial begin
        vec_t v;
        int   tt, guard;

        tbl[0] = chw(mk(4, 4'b0001, 1'b0, 1'b0, 10), 0, 10, 1000, 0, 0);
        tbl[1] = chw(mk(0, 4'b0010, 1'b1, 1'b0, 20), 1, -5, 15, 20, 1000);
        tbl[2] = chw(mk(0, 4'b0010, 1'b0, 1'b0, 1), 1, -5, 15, 20, 1000);
        tbl[3] = chw(chw(mk(0, 4'b0101, 1'b0, 1'b1, 12), 0, 5, 31, 0, 0), 2, 12, 13, 0, 0);
        tbl[4] = chw(chw(mk(0, 4'b0101, 1'b0, 1'b0, 5), 0, 5, 31, 0, 0), 2, 12, 13, 0, 0);
        tbl[5] = chw(mk(15, 4'b0001, 1'b0, 1'b0, 40), 0, 40, 1000, 0, 0);
        tbl[6] = chw(mk(8, 4'b0001, 1'b0, 1'b0, 12), 0, 2, 4, 12, 1000);
        tbl[7] = chw(mk(3, 4'b0001, 1'b1, 1'b0, 10), 0, 2, 6, 10, 1000);
        tbl[8] = chw(chw(mk(2, 4'b0011, 1'b1, 1'b1, 9), 0, 3, 5, 9, 1000), 1, 9, 1000, 0, 0);
        tbl[9] = chw(mk(15, 4'b1000, 1'b0, 1'b0, 16), 3, 0, 1000, 0, 0);

        step();
        step();
        chk("reset state", 32'(state_o), 32'd0);
        chk("reset done", 32'(done_o), 32'd0);
        chk("reset rd_valid", 32'(rd_valid_o), 32'd0);
        chk("reset rd_data", 32'(rd_data_o), 32'd0);
        chk("reset trig_addr", 32'(trig_addr_o), 32'd0);
        rst_i = 1'b0;
        step();

        rd_en_i   = 1'b1;
        rd_addr_i = 4'd3;
        step();
        rd_en_i = 1'b0;
        chk("idle read valid", 32'(rd_valid_o), 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_capture(tbl[i], tbl[i].exp_t, $sformatf("tbl%0d", i));
        end

        // Abort in POST.
        pretrig_i = 4'd2; trig_mask_i = 4'b0001; trig_edge_i = 1'b0; trig_and_i = 1'b0;
        trig_i = 4'hF;
        arm_i = 1'b1;
        step();
        arm_i = 1'b0;
        guard = 0;
        while (state_o != 3'd3 && guard < 20) begin
            step();
            guard++;
        end
        chk("reach POST", 32'(state_o), 32'd3);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk("abort state", 32'(state_o), 32'd0);
        chk("abort done", 32'(done_o), 32'd0);

        arm_i = 1'b1;
        abort_i = 1'b1;
        step();
        arm_i = 1'b0;
        abort_i = 1'b0;
        chk("arm+abort state", 32'(state_o), 32'd0);

        // Empty mask with AND combine must never trigger.
        pretrig_i = 4'd0; trig_mask_i = 4'b0000; trig_and_i = 1'b1; trig_i = 4'hF;
        arm_i = 1'b1;
        step();
        arm_i = 1'b0;
        for (int i = 0; i < 30; i++) begin
            trig_i = 4'(i);
            step();
        end
        chk("mask0 state", 32'(state_o), 32'd2);
        chk("mask0 done", 32'(done_o), 32'd0);

        // Asynchronous reset mid-cycle while waiting for a trigger.
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("async state", 32'(state_o), 32'd0);
        chk("async done", 32'(done_o), 32'd0);
        chk("async rd_valid", 32'(rd_valid_o), 32'd0);
        chk("async rd_data", 32'(rd_data_o), 32'd0);
        chk("async trig_addr", 32'(trig_addr_o), 32'd0);
        step();
        step();
        rst_i = 1'b0;
        step();
        run_capture(tbl[0], tbl[0].exp_t, "post_reset");

        for (int r = 0; r < 10; r++) begin
            tt = 36 + int'($urandom_range(0, 20));
            v  = mk(int'($urandom_range(0, 15)), int'($urandom_range(1, 15)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
            for (int ch = 0; ch < 4; ch++) begin
                int on0;
                on0 = int'($urandom_range(0, 25)) - 3;
                v = chw(v, ch, on0, on0 + int'($urandom_range(0, 8)), tt, 1000);
            end
            v.exp_t = model_trig(v);
            run_capture(v, v.exp_t, $sformatf("rand%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
